lsu_rmw: RTL and testbench
==========================

Name: lsu_rmw

Overview:
Load/store unit placed directly upstream of the word-aligned data memory. It accepts byte, halfword and word requests from the datapath and drives the memory's word address, write data and write enable. It consumes the memory's combinational read data. Sub-word stores are done as a read-modify-write over two cycles, and loads are returned sign- or zero-extended.

Parameters:
MEM_BYTES, 65536, size of the backing byte memory; any access with addr >= MEM_BYTES is flagged as an error.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous reset, active-low
req_valid  input  1  request present
req_ready  output  1  unit can accept; high only in IDLE
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  valid with resp_valid: misaligned, reserved size or out of range
resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors
mem_adr  output  32  word address to memory, always {addr_q[31:2],2'b00}
mem_wd  output  32  write word to memory
mem_write  output  1  memory write enable
mem_rdata  input  32  memory read word (combinational from mem_adr)

Behaviour:
- Little-endian. Byte lane k = bits [8k+7:8k], selected by addr[1:0]. Halfword lane = addr[1].
- Accept: request is accepted when req_valid && req_ready at a rising edge. addr, size, write, unsigned and wdata are registered (addr_q etc.). Inputs are ignored while not in IDLE.
- Error check at accept: error if any of
  - size == 11
  - half with addr[0] == 1
  - word with addr[1:0] != 0
  - addr >= MEM_BYTES
- FSM states: IDLE, RD, WR, DONE.
- IDLE transitions on accept:
  - error -> DONE
  - load -> RD
  - word store -> WR
  - byte/half store -> RD
- RD:
  - Load: the extracted, extended lane of mem_rdata is registered into resp_rdata; go to DONE.
  - Sub-word store: merge wdata_q's low byte/half into the selected lane of mem_rdata and register the result as merge_q; go to WR.
- WR: mem_write = 1. mem_wd = merge_q for sub-word stores, wdata_q for word stores. The write commits at the closing edge; go to DONE.
- DONE: resp_valid = 1 and resp_err as determined at accept; go to IDLE. There is no response back-pressure.
- Latency, accept edge to resp_valid cycle:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Next accept is possible on the edge that ends DONE+1, i.e. the first IDLE cycle.
- mem_write is high only in WR, for exactly one cycle per store, and is gated combinationally by rst_n: a low rst_n in the WR cycle suppresses the write.
- mem_wd = 0 outside WR.
- Outputs are registered except req_ready, mem_write, mem_wd and mem_adr, which are decoded from state and registers.
- Reset (rst_n low at an edge), from any state including mid-RMW:
  - state -> IDLE
  - resp_valid, resp_err, resp_rdata, addr_q, wdata_q, merge_q -> 0
  - memory is unmodified
- Reset values of outputs: req_ready 1 (once rst_n is high), resp_valid 0, resp_err 0, resp_rdata 0, mem_write 0, mem_wd 0, mem_adr 0.
- Extension: byte sign-extends bit 7 and half sign-extends bit 15 unless req_unsigned. Word loads ignore req_unsigned.

Test Plan:
1. Word store 0xDEADBEEF @1000, then word load @1000. Required:
   - mem_write high exactly 1 cycle, mem_adr 1000
   - store resp_valid 2 cycles after accept, err 0
   - load resp_rdata 0xDEADBEEF, 2 cycles after accept
2. Byte store 0x5A @1002 over 0xDEADBEEF. Required:
   - RD cycle with mem_write 0, then WR with mem_wd 0xDE5ABEEF
   - subsequent word load returns 0xDE5ABEEF
3. Loads from 0xDE5ABEEF:
   - lb @1003 -> 0xFFFFFFDE
   - lbu @1003 -> 0x000000DE
   - lh @1002 -> 0xFFFFDE5A
   - lhu @1002 -> 0x0000DE5A
   - lb @1000 -> 0xFFFFFFEF
4. Error cases. Each gives resp_valid 1 cycle after accept, resp_err 1, rdata 0, mem_write never high:
   - lw @1001
   - sh @1003
   - size 11 @1000
   - lw @65536
5. Byte store 0x11 @1000, rst_n driven low during the WR cycle. Required:
   - mem_write stays 0
   - state returns to IDLE and req_ready is 1 after rst_n releases
   - word load @1000 returns the prior value 0xDE5ABEEF
6. req_valid held high for three back-to-back loads. Required:
   - req_ready low in RD and DONE
   - accepts are spaced exactly 3 cycles apart
   - each response matches its own address

Source files
------------

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-aligned data memory: byte/half/word access,
// sub-word stores done as a two-cycle read-modify-write, sign/zero-extended loads.
module lsu_rmw #(
    parameter int MEM_BYTES = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} stateT;

    localparam logic [32:0] MemLimit = 33'(MEM_BYTES);

    stateT       state;
    logic [31:0] addrQ;
    logic [1:0]  sizeQ;
    logic        writeQ;
    logic        unsignedQ;
    logic [31:0] wdataQ;
    logic [31:0] mergeQ;

    logic        reqErr;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] loadData;
    logic [31:0] mergeData;

    always_comb begin
        reqErr = (req_size == 2'b11)
              || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
              || ({1'b0, req_addr} >= MemLimit);
    end

    // Lane extraction and merge both work on the registered address and size.
    always_comb begin
        laneByte  = mem_rdata[{addrQ[1:0], 3'b000} +: 8];
        laneHalf  = mem_rdata[{addrQ[1], 4'b0000} +: 16];
        loadData  = 32'd0;
        mergeData = mem_rdata;
        case (sizeQ)
            2'b00: begin
                loadData = unsignedQ ? {24'd0, laneByte} : {{24{laneByte[7]}}, laneByte};
                mergeData[{addrQ[1:0], 3'b000} +: 8] = wdataQ[7:0];
            end
            2'b01: begin
                loadData = unsignedQ ? {16'd0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
                mergeData[{addrQ[1], 4'b0000} +: 16] = wdataQ[15:0];
            end
            2'b10: loadData = mem_rdata;
            default: loadData = 32'd0;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign mem_adr   = {addrQ[31:2], 2'b00};
    // A reset asserted during WR must keep the memory untouched.
    assign mem_write = (state == WR) && rst_n;
    assign mem_wd    = (state == WR) ? ((sizeQ == 2'b10) ? wdataQ : mergeQ) : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addrQ      <= 32'd0;
            sizeQ      <= 2'b00;
            writeQ     <= 1'b0;
            unsignedQ  <= 1'b0;
            wdataQ     <= 32'd0;
            mergeQ     <= 32'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addrQ      <= req_addr;
                        sizeQ      <= req_size;
                        writeQ     <= req_write;
                        unsignedQ  <= req_unsigned;
                        wdataQ     <= req_wdata;
                        resp_rdata <= 32'd0;
                        if (reqErr) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_write && req_size == 2'b10) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (writeQ) begin
                        mergeQ <= mergeData;
                        state  <= WR;
                    end else begin
                        resp_rdata <= loadData;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                WR: begin
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: directed plan plus random traffic checked
// against a byte-array reference model of little-endian memory.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic        mem_write;
    logic [31:0] mem_rdata;

    int checkCount = 0;
    int failCount  = 0;
    int cycleCount = 0;

    logic [31:0] memWords [0:16383];
    logic [7:0]  refMem   [0:65535];

    lsu_rmw #(.MEM_BYTES(65536)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_adr(mem_adr), .mem_wd(mem_wd),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Backing memory the DUT talks to; the reference model is refMem.
    assign mem_rdata = memWords[mem_adr[15:2]];
    always @(posedge clk) if (mem_write) memWords[mem_adr[15:2]] <= mem_wd;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic refError(input logic [1:0] sz, input logic [31:0] addr);
        return (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0)
            || (sz == 2'd2 && addr % 4 != 0) || (addr >= 32'd65536);
    endfunction

    function automatic logic [31:0] refLoad(input logic [1:0] sz, input logic uns, input logic [31:0] addr);
        logic [31:0] v = 32'd0;
        int nb = 1 << sz;
        for (int i = 0; i < nb; i++) v = v + (32'(refMem[int'(addr) + i]) << (8 * i));
        if (!uns && sz == 2'd0 && v >= 32'h80) v = v + 32'hFFFFFF00;
        if (!uns && sz == 2'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
        return v;
    endfunction

    task automatic refStore(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        int nb = 1 << sz;
        for (int i = 0; i < nb; i++) refMem[int'(addr) + i] = 8'((wd >> (8 * i)) & 32'hFF);
    endtask

    function automatic logic [31:0] refWord(input logic [31:0] addr);
        logic [31:0] v = 32'd0;
        int base = int'(addr) / 4 * 4;
        for (int i = 0; i < 4; i++) v = v + (32'(refMem[base + i]) << (8 * i));
        return v;
    endfunction

    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd);
        logic        err = refError(sz, addr);
        logic [31:0] expData = 32'd0;
        logic [31:0] expWord = 32'd0;
        logic [31:0] wdSeen = 32'd0;
        logic [31:0] adrSeen = 32'd0;
        int expLat, expWrites, lat = 0, writes = 0;
        logic got = 1'b0;
        if (!err && !wr) expData = refLoad(sz, uns, addr);
        if (!err && wr) begin
            refStore(sz, addr, wd);
            expWord = refWord(addr);
        end
        expLat    = err ? 1 : (wr && sz != 2'd2) ? 3 : 2;
        expWrites = (wr && !err) ? 1 : 0;
        @(negedge clk);
        checkOutput("readyIdle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (mem_write) begin
                writes++;
                wdSeen = mem_wd;
                adrSeen = mem_adr;
            end
            if (resp_valid) begin
                got = 1'b1;
                lat = k;
                checkOutput("respErr", 32'(resp_err), 32'(err));
                checkOutput("respData", resp_rdata, expData);
            end
        end
        checkOutput("respLatency", 32'(lat), 32'(expLat));
        checkOutput("memWriteCount", 32'(writes), 32'(expWrites));
        if (writes == 1 && expWrites == 1) begin
            checkOutput("memWd", wdSeen, expWord);
            checkOutput("memAdr", adrSeen, addr & 32'hFFFFFFFC);
        end
        @(negedge clk);
        checkOutput("respPulse", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int acceptCycle [3];
        logic [31:0] b2bAddr [3];
        logic [1:0]  b2bSize [3];
        logic [31:0] expData;
        int waitCnt;

        for (int i = 0; i < 65536; i++) refMem[i] = 8'($urandom);
        for (int i = 0; i < 16384; i++) memWords[i] = refWord(32'(i * 4));

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("rstRespValid", 32'(resp_valid), 32'd0);
        checkOutput("rstRespErr", 32'(resp_err), 32'd0);
        checkOutput("rstRespData", resp_rdata, 32'd0);
        checkOutput("rstMemWrite", 32'(mem_write), 32'd0);
        checkOutput("rstMemAdr", mem_adr, 32'd0);
        checkOutput("rstMemWd", mem_wd, 32'd0);
        rst_n = 1'b1;
        #1 checkOutput("rstReady", 32'(req_ready), 32'd1);

        $display("[TB] word store/load");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'd1000, 32'hDEADBEEF);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'd1000, 32'd0);
        $display("[TB] byte read-modify-write");
        applyStimulus(1'b1, 2'd0, 1'b0, 32'd1002, 32'h0000005A);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'd1000, 32'd0);
        checkOutput("rmwMemory", memWords[250], 32'hDE5ABEEF);
        $display("[TB] sub-word loads");
        applyStimulus(1'b0, 2'd0, 1'b0, 32'd1003, 32'd0);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'd1003, 32'd0);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'd1002, 32'd0);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'd1002, 32'd0);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'd1000, 32'd0);
        $display("[TB] error cases");
        applyStimulus(1'b0, 2'd2, 1'b0, 32'd1001, 32'd0);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'd1003, 32'h1234);
        applyStimulus(1'b0, 2'd3, 1'b0, 32'd1000, 32'd0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'd65536, 32'd0);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'd65532, 32'hCAFEF00D);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'd65532, 32'd0);

        $display("[TB] reset during write");
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd1000; req_wdata = 32'h11;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstRdNoWrite", 32'(mem_write), 32'd0);
        @(negedge clk);
        checkOutput("rstWrActive", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1 checkOutput("rstWrSuppressed", 32'(mem_write), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rstAfterReady", 32'(req_ready), 32'd1);
        checkOutput("rstAfterValid", 32'(resp_valid), 32'd0);
        checkOutput("rstAfterAdr", mem_adr, 32'd0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'd1000, 32'd0);

        $display("[TB] back-to-back loads");
        b2bAddr[0] = 32'd1000; b2bSize[0] = 2'd2;
        b2bAddr[1] = 32'd1002; b2bSize[1] = 2'd1;
        b2bAddr[2] = 32'd1003; b2bSize[2] = 2'd0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_write = 1'b0; req_size = b2bSize[i];
            req_unsigned = 1'b0; req_addr = b2bAddr[i];
            expData = refLoad(b2bSize[i], 1'b0, b2bAddr[i]);
            waitCnt = 0;
            while (!req_ready && waitCnt < 10) begin
                @(negedge clk);
                waitCnt++;
            end
            checkOutput("b2bReady", 32'(req_ready), 32'd1);
            acceptCycle[i] = cycleCount;
            @(negedge clk);
            checkOutput("b2bReadyRd", 32'(req_ready), 32'd0);
            @(negedge clk);
            checkOutput("b2bReadyDone", 32'(req_ready), 32'd0);
            checkOutput("b2bValid", 32'(resp_valid), 32'd1);
            checkOutput("b2bData", resp_rdata, expData);
            @(negedge clk);
        end
        req_valid = 1'b0;
        checkOutput("b2bSpacing01", 32'(acceptCycle[1] - acceptCycle[0]), 32'd3);
        checkOutput("b2bSpacing12", 32'(acceptCycle[2] - acceptCycle[1]), 32'd3);

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'd65532 + 32'($urandom_range(0, 7));
                default: a = 32'($urandom_range(0, 63));
            endcase
            applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
        end
        for (int w = 0; w < 16; w++)
            applyStimulus(1'b0, 2'd2, 1'b0, 32'(w * 4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
